// File: rtl/pulse_sched_arbiter.sv
// Round-robin front end that shares one pulse generator between NREQ requesters.
// Grants one request per burst, triggers the generator, supervises it and reports done/err.
module pulse_sched_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLDOFF  = 16,
    parameter int START_TO = 4,
    parameter int DONE_TO  = 2047
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_repeats,
    output logic [NREQ-1:0]     gnt,
    output logic                done,
    output logic                err,
    output logic                busy,
    output logic                pg_trigger,
    output logic [1:0]          pg_repeats,
    input  logic                pg_ena
);

    localparam int HOLD_V = (HOLDOFF < 1) ? 1 : HOLDOFF;
    localparam int MAXC_A = (DONE_TO > START_TO) ? DONE_TO : START_TO;
    localparam int MAXC   = (MAXC_A > HOLD_V) ? MAXC_A : HOLD_V;
    localparam int CNT_W  = $clog2(MAXC + 1);
    localparam int IDX_W  = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_START,
        S_WAIT_DONE,
        S_DONE,
        S_HOLD
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [NREQ-1:0]    r_gnt;
    logic               r_done;
    logic               r_err;
    logic               r_busy;
    logic               r_trig;
    logic [1:0]         r_rep;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [1:0]         w_win_rep;
    logic [IDX_W-1:0]   w_rr_next;

    // First pending request at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDX_W'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    assign w_win_rep = req_repeats[2*int'(w_win) +: 2];
    assign w_rr_next = (int'(r_gnt_idx) == NREQ - 1) ? '0 : r_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_gnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_trig    <= 1'b0;
            r_rep     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx <= w_win;
                        r_gnt     <= NREQ'(1) << w_win;
                        r_rep     <= w_win_rep;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                        // A zero-length burst completes without touching the generator.
                        if (w_win_rep == 2'd0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_trig  <= 1'b1;
                            r_state <= S_TRIG;
                        end
                    end
                end
                S_TRIG: begin
                    r_trig  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (!pg_ena) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == CNT_W'(START_TO - 1)) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (pg_ena) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_W'(DONE_TO - 1)) begin
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done   <= 1'b0;
                    r_err    <= 1'b0;
                    r_gnt    <= '0;
                    r_rr_ptr <= w_rr_next;
                    r_cnt    <= CNT_W'(HOLD_V);
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_gnt   <= '0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_trig  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign done       = r_done;
    assign err        = r_err;
    assign busy       = r_busy;
    assign pg_trigger = r_trig;
    assign pg_repeats = r_rep;

endmodule
